// File: rtl/digital_temp_spi_reader.sv
// LM70-style SPI temperature reader: clocks out 16-bit frames, validates the
// D4..D2 marker, latches an 11-bit code and raises threshold alarms.
`timescale 1ns/1ps
module digital_temp_spi_reader #(
    parameter int HALF_DIV = 2,
    parameter int GAP      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        auto_en,
    input  logic        sio,
    input  logic [8:0]  th_hi,
    input  logic [8:0]  th_lo,
    output logic        cs,
    output logic        sck,
    output logic [10:0] temp_code,
    output logic        temp_valid,
    output logic        frame_err,
    output logic        busy,
    output logic        alarm_hi,
    output logic        alarm_lo
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, END, GAP_WAIT} state_t;

    localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t      state, state_d;
    logic [7:0]  div, div_d;
    logic [5:0]  halves, halves_d;
    logic [7:0]  gap_cnt, gap_cnt_d;
    logic [15:0] shreg, shreg_d;
    logic        cs_d, sck_d, valid_d, err_d, ahi_d, alo_d;
    logic [10:0] code_d;
    logic [10:0] new_code;
    logic [8:0]  new_deg;
    logic        div_done;

    assign div_done = (div == DIV_LAST);
    assign new_code = shreg[15:5];
    // Whole degrees are the code with its two fractional bits dropped.
    assign new_deg  = new_code[10:2];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            halves     <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            cs         <= 1'b1;
            sck        <= 1'b0;
            temp_code  <= '0;
            temp_valid <= 1'b0;
            frame_err  <= 1'b0;
            alarm_hi   <= 1'b0;
            alarm_lo   <= 1'b0;
        end else begin
            state      <= state_d;
            div        <= div_d;
            halves     <= halves_d;
            gap_cnt    <= gap_cnt_d;
            shreg      <= shreg_d;
            cs         <= cs_d;
            sck        <= sck_d;
            temp_code  <= code_d;
            temp_valid <= valid_d;
            frame_err  <= err_d;
            alarm_hi   <= ahi_d;
            alarm_lo   <= alo_d;
        end
    end

    always_comb begin
        state_d   = state;
        div_d     = div;
        halves_d  = halves;
        gap_cnt_d = gap_cnt;
        shreg_d   = shreg;
        cs_d      = cs;
        sck_d     = sck;
        code_d    = temp_code;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        ahi_d     = alarm_hi;
        alo_d     = alarm_lo;
        case (state)
            IDLE: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
                if (start || auto_en) begin
                    state_d  = SETUP;
                    cs_d     = 1'b0;
                    div_d    = '0;
                    halves_d = '0;
                end
            end
            SETUP: begin
                if (div_done) begin
                    // First rising SCK edge; capture D15.
                    div_d    = '0;
                    sck_d    = 1'b1;
                    shreg_d  = {shreg[14:0], sio};
                    halves_d = 6'd1;
                    state_d  = SHIFT;
                end else begin
                    div_d = div + 8'd1;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_d = '0;
                    if (halves == 6'd32) begin
                        // Trailing half-period elapsed: close the frame.
                        state_d = END;
                        cs_d    = 1'b1;
                        sck_d   = 1'b0;
                        if (shreg[4:2] == 3'b111) begin
                            code_d  = new_code;
                            valid_d = 1'b1;
                            ahi_d   = $signed(new_deg) >= $signed(th_hi);
                            alo_d   = $signed(new_deg) <= $signed(th_lo);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        sck_d    = ~sck;
                        halves_d = halves + 6'd1;
                        if (!sck) shreg_d = {shreg[14:0], sio};
                    end
                end else begin
                    div_d = div + 8'd1;
                end
            end
            END: begin
                if (!auto_en) begin
                    state_d = IDLE;
                end else if (GAP == 0) begin
                    state_d  = SETUP;
                    cs_d     = 1'b0;
                    div_d    = '0;
                    halves_d = '0;
                end else begin
                    state_d   = GAP_WAIT;
                    gap_cnt_d = '0;
                end
            end
            GAP_WAIT: begin
                if (gap_cnt == GAP_LAST) begin
                    if (auto_en) begin
                        state_d  = SETUP;
                        cs_d     = 1'b0;
                        div_d    = '0;
                        halves_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sck_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_digital_temp_spi_reader.sv
// Bench for digital_temp_spi_reader: an LM70 sensor model drives sio, and a
// frame-level reference model predicts code, pulses, latency and alarms.
`timescale 1ns/1ps
module tb_digital_temp_spi_reader;

    localparam int HALF_DIV = 2;
    localparam int GAP      = 8;
    localparam int LAT      = 33 * HALF_DIV;
    localparam int PERIOD   = LAT + 1 + GAP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        sio;
    logic [8:0]  th_hi = 9'd100;
    logic [8:0]  th_lo = 9'h1EC;
    logic        cs, sck, temp_valid, frame_err, busy, alarm_hi, alarm_lo;
    logic [10:0] temp_code;

    int total = 0;
    int bad   = 0;

    logic [15:0] cur_frame = 16'h0000;
    int          rises = 0;

    logic [10:0] exp_code = '0;
    logic        exp_hi = 1'b0;
    logic        exp_lo = 1'b0;

    digital_temp_spi_reader #(.HALF_DIV(HALF_DIV), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .sio(sio),
        .th_hi(th_hi), .th_lo(th_lo), .cs(cs), .sck(sck),
        .temp_code(temp_code), .temp_valid(temp_valid), .frame_err(frame_err),
        .busy(busy), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo)
    );

    always #5 clk = ~clk;

    // Sensor: presents bit D(15-n) after n rising SCK edges of the frame.
    always @(negedge cs) rises = 0;
    always @(posedge sck) rises = rises + 1;
    assign sio = (rises < 16) ? cur_frame[15 - rises] : 1'b0;

    function automatic int code_to_deg(input logic [10:0] code);
        int c;
        c = int'(code);
        if (c >= 1024) c = c - 2048;
        return (c >= 0) ? c / 4 : -((-c + 3) / 4);
    endfunction

    function automatic int th_int(input logic [8:0] th);
        int t;
        t = int'(th);
        return (t >= 256) ? t - 512 : t;
    endfunction

    // Frame-level reference: what the reader should conclude from one frame.
    task automatic model_frame(input logic [15:0] f);
        int deg;
        if (((f >> 2) & 16'd7) == 16'd7) begin
            exp_code = f[15:5];
            deg      = code_to_deg(f[15:5]);
            exp_hi   = deg >= th_int(th_hi);
            exp_lo   = deg <= th_int(th_lo);
        end
    endtask

    // One start-triggered frame; reports latency and pulse/edge counts.
    task automatic do_frame(input logic [15:0] f, output int lat, output int nv,
                            output int ne, output int rs, output int csl);
        cur_frame = f;
        lat = -1; nv = 0; ne = 0; csl = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (cs === 1'b0) csl++;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(posedge clk); #1;
            if (cs === 1'b0) csl++;
            if (temp_valid === 1'b1) begin nv++; if (lat < 0) lat = c; end
            if (frame_err === 1'b1) begin ne++; if (lat < 0) lat = c; end
        end
        rs = rises;
        model_frame(f);
    endtask

    task automatic check_outputs(input string name);
        total++;
        if (temp_code !== exp_code || alarm_hi !== exp_hi || alarm_lo !== exp_lo) begin
            bad++;
            $display("FAIL %s: code=%h hi=%b lo=%b, required code=%h hi=%b lo=%b",
                     name, temp_code, alarm_hi, alarm_lo, exp_code, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (cs !== 1'b1 || sck !== 1'b0 || temp_code !== 11'd0 || temp_valid !== 1'b0 ||
            frame_err !== 1'b0 || busy !== 1'b0 || alarm_hi !== 1'b0 || alarm_lo !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: cs=%b sck=%b code=%h v=%b e=%b busy=%b hi=%b lo=%b, required 1 0 000 0 0 0 0 0",
                     cs, sck, temp_code, temp_valid, frame_err, busy, alarm_hi, alarm_lo);
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || cs !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b cs=%b, required 0 1", busy, cs);
        end
    endtask

    task automatic test_basic();
        int lat, nv, ne, rs, csl;
        th_lo = 9'(-20); th_hi = 9'd100;
        do_frame(16'hF39F, lat, nv, ne, rs, csl);
        total++;
        if (lat !== LAT || nv !== 1 || ne !== 0) begin
            bad++;
            $display("FAIL basic_pulse: lat=%0d valid=%0d err=%0d, required %0d 1 0", lat, nv, ne, LAT);
        end
        total++;
        if (rs !== 16 || csl !== LAT) begin
            bad++;
            $display("FAIL basic_bus: rises=%0d cs_low=%0d, required 16 %0d", rs, csl, LAT);
        end
        total++;
        if (temp_code !== 11'h79C) begin
            bad++;
            $display("FAIL basic_code: code=%h, required 79c", temp_code);
        end
        check_outputs("basic_alarm");
        total++;
        if (alarm_lo !== 1'b1 || alarm_hi !== 1'b0) begin
            bad++;
            $display("FAIL basic_alarm_const: hi=%b lo=%b, required 0 1", alarm_hi, alarm_lo);
        end
    endtask

    task automatic test_hot();
        int lat, nv, ne, rs, csl;
        th_lo = 9'(-20); th_hi = 9'd100;
        do_frame({11'h258, 3'b111, 2'b10}, lat, nv, ne, rs, csl);
        total++;
        if (nv !== 1 || temp_code !== 11'h258 || alarm_hi !== 1'b1 || alarm_lo !== 1'b0) begin
            bad++;
            $display("FAIL hot_frame: valid=%0d code=%h hi=%b lo=%b, required 1 258 1 0",
                     nv, temp_code, alarm_hi, alarm_lo);
        end
    endtask

    task automatic test_bad_frame();
        int lat, nv, ne, rs, csl;
        do_frame(16'h0000, lat, nv, ne, rs, csl);
        total++;
        if (ne !== 1 || nv !== 0 || lat !== LAT) begin
            bad++;
            $display("FAIL bad_frame_pulse: err=%0d valid=%0d lat=%0d, required 1 0 %0d", ne, nv, lat, LAT);
        end
        check_outputs("bad_frame_hold");
    endtask

    task automatic test_both_alarms();
        int lat, nv, ne, rs, csl;
        th_lo = 9'd50; th_hi = 9'd10;
        do_frame({11'(30 * 4 + 1), 3'b111, 2'b01}, lat, nv, ne, rs, csl);
        total++;
        if (alarm_hi !== 1'b1 || alarm_lo !== 1'b1) begin
            bad++;
            $display("FAIL both_alarms: hi=%b lo=%b, required 1 1", alarm_hi, alarm_lo);
        end
        check_outputs("both_alarms_model");
    endtask

    task automatic test_random();
        int lat, nv, ne, rs, csl;
        logic [15:0] f;
        logic good;
        for (int i = 0; i < 10; i++) begin
            good = ($urandom_range(0, 3) != 0);
            f[15:5] = 11'($urandom_range(0, 2047));
            f[4:2]  = good ? 3'b111 : 3'($urandom_range(0, 6));
            f[1:0]  = 2'($urandom_range(0, 3));
            th_hi   = 9'($urandom_range(0, 511));
            th_lo   = 9'($urandom_range(0, 511));
            do_frame(f, lat, nv, ne, rs, csl);
            total++;
            if (nv !== int'(good) || ne !== int'(!good) || lat !== LAT) begin
                bad++;
                $display("FAIL random_pulse[%0d]: frame=%h valid=%0d err=%0d lat=%0d, required %0d %0d %0d",
                         i, f, nv, ne, lat, good, !good, LAT);
            end
            check_outputs("random_result");
        end
    endtask

    task automatic test_reset_mid();
        int nv, ne, nb, lat, rs, csl;
        cur_frame = 16'hF39F;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_code = '0; exp_hi = 1'b0; exp_lo = 1'b0;
        total++;
        if (cs !== 1'b1 || sck !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_bus: cs=%b sck=%b busy=%b, required 1 0 0", cs, sck, busy);
        end
        check_outputs("reset_mid_clear");
        @(posedge clk); #1;
        rst = 1'b0;
        nv = 0; ne = 0; nb = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (temp_valid === 1'b1) nv++;
            if (frame_err === 1'b1) ne++;
            if (busy !== 1'b0) nb++;
        end
        total++;
        if (nv !== 0 || ne !== 0 || nb !== 0) begin
            bad++;
            $display("FAIL reset_mid_quiet: valid=%0d err=%0d busy_cycles=%0d, required 0 0 0", nv, ne, nb);
        end
        th_lo = 9'(-20); th_hi = 9'd100;
        do_frame(16'hF39F, lat, nv, ne, rs, csl);
        total++;
        if (nv !== 1 || lat !== LAT) begin
            bad++;
            $display("FAIL reset_mid_restart: valid=%0d lat=%0d, required 1 %0d", nv, lat, LAT);
        end
        check_outputs("reset_mid_restart_code");
    endtask

    task automatic test_auto();
        int times[$];
        cur_frame = {11'h0A4, 3'b111, 2'b11};
        auto_en = 1'b1;
        for (int c = 1; c <= 420; c++) begin
            @(posedge clk); #1;
            if (temp_valid === 1'b1) times.push_back(c);
            start   = (c == 100 || c == 180);
            if (c == 310) auto_en = 1'b0;
        end
        start = 1'b0;
        model_frame(cur_frame);
        total++;
        if (times.size() != 5) begin
            bad++;
            $display("FAIL auto_count: pulses=%0d, required 5", times.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                total++;
                if (times[i] - times[i-1] != PERIOD) begin
                    bad++;
                    $display("FAIL auto_period[%0d]: interval=%0d, required %0d",
                             i, times[i] - times[i-1], PERIOD);
                end
            end
            total++;
            if (times[0] != LAT + 1) begin
                bad++;
                $display("FAIL auto_first: cycle=%0d, required %0d", times[0], LAT + 1);
            end
        end
        total++;
        if (busy !== 1'b0 || cs !== 1'b1) begin
            bad++;
            $display("FAIL auto_stop: busy=%b cs=%b, required 0 1", busy, cs);
        end
        check_outputs("auto_code");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hot();
        test_bad_frame();
        test_both_alarms();
        test_random();
        test_reset_mid();
        test_auto();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
